// File: rtl/wb_cmd_master.sv
// wb_cmd_master
// Wishbone initiator that turns a host byte-command stream into single
// read/write cycles on an 8-bit data, 4-bit address register bus. Every
// command produces exactly one response byte, and every bus cycle is
// guarded by an ack timeout.
//
// Command format: header byte {we, 3'bx, adr[3:0]}; a write is followed
// by one data byte, a read is header only.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_data/valid/ready  host command byte stream (input side)
//   rsp_data/err/valid/ready  host response byte stream (output side)
//   busy                  high whenever the FSM is not idle
//   stb_o, we_o, adr_o, dat_o  bus request toward the register slave
//   dat_i, ack_i          bus read data and acknowledge from the slave
//
// Parameters
//   STB_PULSE  1: strobe for one cycle, then wait for ack with strobe low
//              0: classic mode, strobe held until ack
//   TIMEOUT    ack wait limit in cycles from the strobe edge (2..255)

module wb_cmd_master #(
    parameter bit          STB_PULSE = 1'b1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       busy,
    output logic       stb_o,
    output logic       we_o,
    output logic [3:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    input  logic       ack_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_DATA,
        S_BUS,
        S_WAIT,
        S_RESP
    } state_t;

    // The counter is cleared on the strobe edge T and incremented on every
    // WAIT edge, so on edge T+k it holds k-1 before the update. Firing on
    // TIMEOUT-1 therefore lands the timeout response exactly on T+TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_stb;
    logic       r_we;
    logic [3:0] r_adr;
    logic [7:0] r_dat;
    logic [7:0] r_rsp_data;
    logic       r_rsp_err;
    logic       r_rsp_valid;

    // Header bits 6:4 carry no meaning.
    logic w_hdr_unused;
    assign w_hdr_unused = ^cmd_data[6:4];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 4'd0;
            r_dat       <= 8'd0;
            r_rsp_data  <= 8'd0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_we    <= cmd_data[7];
                        r_adr   <= cmd_data[3:0];
                        r_state <= cmd_data[7] ? S_GET_DATA : S_BUS;
                    end
                end
                S_GET_DATA: begin
                    if (cmd_valid) begin
                        r_dat   <= cmd_data;
                        r_state <= S_BUS;
                    end
                end
                S_BUS: begin
                    r_stb   <= 1'b1;
                    r_cnt   <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (ack_i) begin
                        r_stb       <= 1'b0;
                        r_rsp_data  <= r_we ? 8'h00 : dat_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_cnt == TMO_LAST) begin
                        r_stb       <= 1'b0;
                        r_rsp_data  <= 8'h00;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (STB_PULSE) begin
                            r_stb <= 1'b0;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // cmd_ready is gated by rst_i so no byte is taken during reset.
    assign cmd_ready = !rst_i && ((r_state == S_IDLE) || (r_state == S_GET_DATA));
    assign busy      = (r_state != S_IDLE);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign rsp_valid = r_rsp_valid;
    assign stb_o     = r_stb;
    assign we_o      = r_we;
    assign adr_o     = r_adr;
    assign dat_o     = r_dat;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master. Three instances share clock and reset:
//   0: STB_PULSE=1, TIMEOUT=255, registered-ack slave with a register file
//   1: STB_PULSE=1, TIMEOUT=8,   slave that never acks (ack_en=0) + forced late ack
//   2: STB_PULSE=0, TIMEOUT=255, registered-ack slave (acks twice in hold mode)
// Slaves 1 and 2 return 0xC0 | adr as read data.

module tb_wb_cmd_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd_data [3];
    logic [2:0] cmd_valid, cmd_ready, rsp_err, rsp_valid, rsp_ready, busy;
    logic [2:0] stb, we, ack, ack_r, ack_en, late_ack;
    logic [7:0] rsp_data [3];
    logic [7:0] dato [3];
    logic [7:0] dati [3];
    logic [3:0] adr [3];
    logic [7:0] rf [16];
    int         wr_cnt;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_cmd_master #(
            .STB_PULSE (g == 2 ? 1'b0 : 1'b1),
            .TIMEOUT   (g == 1 ? 8 : 255)
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .cmd_data  (cmd_data[g]),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .rsp_data  (rsp_data[g]),
            .rsp_err   (rsp_err[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .busy      (busy[g]),
            .stb_o     (stb[g]),
            .we_o      (we[g]),
            .adr_o     (adr[g]),
            .dat_o     (dato[g]),
            .dat_i     (dati[g]),
            .ack_i     (ack[g])
        );
        assign ack[g] = ack_r[g] | late_ack[g];
        if (g == 0) begin : g_rf
            assign dati[g] = rf[adr[g]];
        end else begin : g_const
            assign dati[g] = 8'hC0 | {4'h0, adr[g]};
        end
    end

    // Registered-ack slave: ack follows a sampled strobe by one edge.
    always @(posedge clk) begin
        if (rst) begin
            ack_r  <= 3'b000;
            wr_cnt <= 0;
            for (int k = 0; k < 16; k++) rf[k] <= 8'h00;
        end else begin
            ack_r <= stb & ack_en;
            if (stb[0] && ack_en[0] && we[0]) begin
                rf[adr[0]] <= dato[0];
                wr_cnt     <= wr_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int i, input logic [7:0] b);
        cmd_data[i]  = b;
        cmd_valid[i] = 1'b1;
        tick();
        cmd_valid[i] = 1'b0;
    endtask

    // Full command on instance i with a slave that acks at T+1..T+2.
    // bp = cycles of rsp_ready=0 held after the response appears.
    task automatic do_cmd(input int i, input logic [7:0] hdr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input int bp);
        send(i, hdr);
        if (hdr[7]) send(i, wd);
        chk("cmd_ready_bus", cmd_ready[i], 0);
        tick();  // T
        chk("stb_T", stb[i], 1);
        chk("we_T", we[i], hdr[7]);
        chk("adr_T", adr[i], hdr[3:0]);
        if (hdr[7]) chk("dat_o_T", dato[i], wd);
        tick();  // T+1
        chk("stb_T1", stb[i], (i == 2));
        chk("vld_T1", rsp_valid[i], 0);
        tick();  // T+2
        chk("vld_T2", rsp_valid[i], 1);
        chk("err_T2", rsp_err[i], 0);
        chk("rdata_T2", rsp_data[i], hdr[7] ? 8'h00 : exp_rd);
        chk("stb_T2", stb[i], 0);
        for (int c = 0; c < bp; c++) begin
            tick();
            chk("bp_vld", rsp_valid[i], 1);
            chk("bp_data", rsp_data[i], hdr[7] ? 8'h00 : exp_rd);
            chk("bp_cmd_ready", cmd_ready[i], 0);
            chk("bp_busy", busy[i], 1);
        end
        rsp_ready[i] = 1'b1;
        tick();
        rsp_ready[i] = 1'b0;
        chk("vld_after_hs", rsp_valid[i], 0);
        chk("busy_after_hs", busy[i], 0);
        tick();
        chk("single_rsp", rsp_valid[i], 0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 3'b000;
        rsp_ready = 3'b000;
        late_ack  = 3'b000;
        ack_en    = 3'b101;
        for (int k = 0; k < 3; k++) cmd_data[k] = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready[0], 0);
        chk("rst_stb", stb[0], 0);
        chk("rst_we", we[0], 0);
        chk("rst_adr", adr[0], 0);
        chk("rst_dat_o", dato[0], 0);
        chk("rst_rsp_valid", rsp_valid[0], 0);
        chk("rst_rsp_data", rsp_data[0], 0);
        chk("rst_rsp_err", rsp_err[0], 0);
        chk("rst_busy", busy[0], 0);
        rst = 1'b0;
        #1;
        chk("cmd_ready_idle", cmd_ready[0], 1);

        // Write 0x5A to address 2
        do_cmd(0, 8'h82, 8'h5A, 8'h00, 0);
        chk("rf2_written", rf[2], 8'h5A);
        chk("single_write", wr_cnt, 1);

        // Read back, plain header and with bits 6:4 set plus backpressure
        do_cmd(0, 8'h02, 8'h00, 8'h5A, 0);
        do_cmd(0, 8'h72, 8'h00, 8'h5A, 5);
        chk("no_extra_write", wr_cnt, 1);

        // Timeout on instance 1 (TIMEOUT=8, slave never acks)
        send(1, 8'h03);
        tick();  // T
        chk("tmo_stb_T", stb[1], 1);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("tmo_no_vld", rsp_valid[1], 0);
            chk("tmo_stb_low", stb[1], 0);
        end
        tick();  // T+8
        chk("tmo_vld", rsp_valid[1], 1);
        chk("tmo_err", rsp_err[1], 1);
        chk("tmo_data", rsp_data[1], 8'h00);
        chk("tmo_stb", stb[1], 0);
        late_ack[1] = 1'b1;
        tick();
        late_ack[1] = 1'b0;
        chk("late_ack_vld", rsp_valid[1], 1);
        chk("late_ack_err", rsp_err[1], 1);
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
        chk("tmo_hs", rsp_valid[1], 0);
        late_ack[1] = 1'b1;
        tick();
        late_ack[1] = 1'b0;
        tick();
        chk("idle_ack_vld", rsp_valid[1], 0);
        chk("idle_ack_busy", busy[1], 0);

        // Hold mode against a double-acking slave
        do_cmd(2, 8'h01, 8'h00, 8'hC1, 1);

        // Reset in WAIT on instance 1
        send(1, 8'h04);
        tick();  // T
        tick();  // T+1, in WAIT
        chk("pre_rst_busy", busy[1], 1);
        rst = 1'b1;
        tick();
        chk("rstw_stb", stb[1], 0);
        chk("rstw_busy", busy[1], 0);
        chk("rstw_vld", rsp_valid[1], 0);
        chk("rstw_cmd_ready", cmd_ready[1], 0);
        rst = 1'b0;
        #1;
        chk("rstw_ready_after", cmd_ready[1], 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rstw_no_rsp", rsp_valid[1], 0);
        end
        ack_en[1] = 1'b1;
        do_cmd(1, 8'h04, 8'h00, 8'hC4, 0);

        // Reset between header and data on instance 0
        send(0, 8'h85);
        chk("getd_busy", busy[0], 1);
        rst = 1'b1;
        tick();
        chk("rstd_busy", busy[0], 0);
        chk("rstd_stb", stb[0], 0);
        rst = 1'b0;
        #1;
        chk("rstd_ready", cmd_ready[0], 1);
        do_cmd(0, 8'h83, 8'h3C, 8'h00, 0);
        chk("rf3_written", rf[3], 8'h3C);
        chk("rf5_untouched", rf[5], 8'h00);
        chk("write_count_after_rst", wr_cnt, 1);
        do_cmd(0, 8'h03, 8'h00, 8'h3C, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone initiator that turns a host byte-command stream (UART or USB FIFO side) into single read/write cycles on the 8-bit data, 4-bit address register bus used by the glitch and peripheral register blocks. Each command produces exactly one response byte. It drives strobe, write-enable, address and data toward a register slave and collects ack and read data. It also guards every cycle with an ack timeout. It sits between the host byte link and the register-slave address decode.

## Interface
- STB_PULSE, 1: 1 = strobe held for exactly one cycle, then the master waits for ack with strobe low (for registered-ack slaves); 0 = classic mode, strobe held until ack.
- TIMEOUT, 255: ack wait limit in clock cycles, counted from the strobe assertion edge; range 2..255; 8-bit counter.
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cmd_data  in  8  host command byte.
- cmd_valid  in  1  cmd_data valid.
- cmd_ready  out  1  byte accepted on an edge where cmd_valid && cmd_ready.
- rsp_data  out  8  response byte.
- rsp_err  out  1  response is a timeout error; qualified by rsp_valid.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host consumes response on an edge where rsp_valid && rsp_ready.
- busy  out  1  high in any state other than IDLE.
- stb_o  out  1  bus strobe.
- we_o  out  1  bus write enable.
- adr_o  out  4  bus address.
- dat_o  out  8  bus write data.
- dat_i  in  8  bus read data; sampled only with ack_i.
- ack_i  in  1  bus acknowledge.

## Operation
- Header byte format: bit7 = we; bits3:0 = address; bits6:4 ignored.
- A write command is two bytes: header, then data. A read command is header only.
- States and transitions:
  - IDLE: cmd_ready=1. Header accept → latch we/adr; write → GET_DATA, read → BUS.
  - GET_DATA: cmd_ready=1. Data accept → latch dat_o, go to BUS.
  - BUS: stb_o=1 for one cycle, timeout counter cleared. STB_PULSE=1 → WAIT with stb_o=0; STB_PULSE=0 → WAIT with stb_o held at 1.
  - WAIT: counter increments each cycle.
    - ack_i=1 → stb_o=0; rsp_data = dat_i on a read or 0x00 on a write; rsp_err=0; go to RESP.
    - Counter reaches TIMEOUT → stb_o=0, rsp_data=0x00, rsp_err=1, go to RESP.
    - ack_i and timeout on the same edge → ack wins.
  - RESP: rsp_valid=1 with rsp_data and rsp_err stable. Handshake → IDLE.
- cmd_ready=0 in BUS, WAIT and RESP, and while rst_i=1.
- ack_i outside WAIT is ignored. A second ack from the slave in hold mode produces no extra response.
- we_o, adr_o and dat_o are stable from the BUS edge until leaving WAIT, then hold their last values.
- Reset values: stb_o=0, we_o=0, adr_o=0, dat_o=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, state=IDLE.
- Reset mid-command, in any state: the next edge returns to IDLE with stb_o=0. Any partial command or pending response is discarded without emission.

## Timing
- Header accept at edge E0. Read: stb_o rises at E0+1. Write: stb_o rises one edge after the data byte is accepted.
- Let T be the edge where stb_o rises. With a slave that sets ack the edge after it samples stb:
  - ack_i is high T+1..T+2.
  - rsp_valid rises at T+2.
  - STB_PULSE=1: stb_o falls at T+1, so the slave samples strobe exactly once.
  - STB_PULSE=0: stb_o falls at T+2. A registered-ack slave samples strobe twice; hold mode is for combinational-ack slaves only.
- Timeout: with no ack, rsp_valid and rsp_err rise at T+TIMEOUT, and stb_o is low from that same edge.
- Back-to-back: the next header can be accepted on the edge after the response handshake. Minimum read turnaround is 4 cycles.

## Test plan
- Write with default params and a registered-ack slave model: bytes 0x82, 0x5A → stb_o high for exactly one cycle, we_o=1, adr_o=2, dat_o=0x5A; rsp_data=0x00, rsp_err=0 at T+2; slave register = 0x5A; single slave write.
- Read back: byte 0x02 → we_o=0, adr_o=2; rsp_data=0x5A at T+2; bits6:4 set in header (0x72) give the same result.
- Timeout with TIMEOUT=8 and a slave that never acks: header 0x03 → rsp_valid=1, rsp_err=1, rsp_data=0x00 at exactly T+8; stb_o=0 from T+8; a late ack afterwards is ignored.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read → rsp_valid and rsp_data stable, cmd_ready=0, busy=1 throughout; a single response is taken when rsp_ready rises.
- Hold mode (STB_PULSE=0) against a double-acking slave: read 0x01 → exactly one response, second ack ignored, stb_o falls at T+2.
- Reset mid-WAIT, and reset after a header but before the data byte: rst_i pulsed → stb_o=0 and state IDLE next edge, no rsp_valid, cmd_ready=1 once rst_i is low; the next full command completes normally.
